// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - turn sequencer for the chicken-race datapath
//
// Runs the turn loop: take a tile pick from the current player, fire a
// single-cycle match-check request, then either move that player's chicken
// (match) or pass the turn (mismatch / pick timeout). Owns positions, step
// counts and win detection.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, N                 begin a game (IDLE/WIN only), player count - 1
//   pick_valid, pick_tile    tile pick from the current player
//   pick_ready               high while waiting for a pick (PICK)
//   same_req                 one-cycle request to the match checker
//   card_sel                 latched pick_tile
//   position_data            target cell of the current chicken
//   same_done, same_result   checker response (CHECK only)
//   T                        current player
//   statecombo_next_turn     one-cycle pulse when the turn passes (NEXT)
//   move_strobe              one-cycle pulse when a chicken moves (MOVE)
//   positions                player i cell at [4i+3:4i]
//   win, winner              game won / winning player
//   state                    IDLE=0 PICK=1 CHECK=2 MOVE=3 NEXT=4 WIN=5
module turn_controller #(
  parameter int WIN_STEPS      = 16,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  N,
  input  logic        pick_valid,
  input  logic [3:0]  pick_tile,
  output logic        pick_ready,
  output logic        same_req,
  output logic [3:0]  card_sel,
  output logic [3:0]  position_data,
  input  logic        same_done,
  input  logic        same_result,
  output logic [1:0]  T,
  output logic        statecombo_next_turn,
  output logic        move_strobe,
  output logic [15:0] positions,
  output logic        win,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PICK  = 3'd1,
    S_CHECK = 3'd2,
    S_MOVE  = 3'd3,
    S_NEXT  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  localparam logic [4:0]  WIN_L = 5'(WIN_STEPS);
  localparam logic [15:0] TO_L  = 16'(TIMEOUT_CYCLES);

  state_t      cur, nxt;
  logic [1:0]  n_lat;
  logic [1:0]  t_q;
  logic [3:0]  pos_q   [4];
  logic [4:0]  steps_q [4];
  logic [3:0]  card_q;
  logic [3:0]  target_q;
  logic [2:0]  dist_q;
  logic [1:0]  winner_q;
  logic        req_q;
  logic [15:0] tcnt;

  // Target search: first cell after the current chicken not held by another
  // active player. At most three other chickens exist, so d never exceeds 4.
  logic [3:0] tgt_c;
  logic [2:0] dist_c;
  logic [3:0] cand;
  logic       occ;
  logic       found;

  always_comb begin
    tgt_c  = pos_q[t_q] + 4'd1;
    dist_c = 3'd1;
    cand   = 4'd0;
    occ    = 1'b0;
    found  = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      cand = pos_q[t_q] + 4'(d);
      occ  = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if ((2'(j) != t_q) && (2'(j) <= n_lat) && (pos_q[j] == cand))
          occ = 1'b1;
      end
      if (!found && !occ) begin
        found  = 1'b1;
        tgt_c  = cand;
        dist_c = 3'(d);
      end
    end
  end

  // Step update for the MOVE cycle, saturating at 31.
  logic [5:0] sum_c;
  logic [4:0] steps_new;
  logic       win_hit;
  logic       timeout_hit;

  assign sum_c       = {1'b0, steps_q[t_q]} + {3'b000, dist_q};
  assign steps_new   = (sum_c > 6'd31) ? 5'd31 : sum_c[4:0];
  assign win_hit     = (steps_new >= WIN_L);
  // Counter is zero on the first PICK cycle, so the forfeit edge is the
  // one ending the TIMEOUT_CYCLES-th PICK cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((tcnt + 16'd1) == TO_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt                  = cur;
    pick_ready           = 1'b0;
    move_strobe          = 1'b0;
    statecombo_next_turn = 1'b0;
    win                  = 1'b0;
    case (cur)
      S_IDLE:  if (start) nxt = S_PICK;
      S_PICK: begin
        pick_ready = 1'b1;
        if (pick_valid)       nxt = S_CHECK;
        else if (timeout_hit) nxt = S_NEXT;
      end
      S_CHECK: if (same_done) nxt = same_result ? S_MOVE : S_NEXT;
      S_MOVE: begin
        move_strobe = 1'b1;
        nxt = win_hit ? S_WIN : S_PICK;
      end
      S_NEXT: begin
        statecombo_next_turn = 1'b1;
        nxt = S_PICK;
      end
      S_WIN: begin
        win = 1'b1;
        if (start) nxt = S_PICK;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat    <= 2'd0;
      t_q      <= 2'd0;
      card_q   <= 4'd0;
      target_q <= 4'd0;
      dist_q   <= 3'd0;
      winner_q <= 2'd0;
      req_q    <= 1'b0;
      tcnt     <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        pos_q[i]   <= 4'(4 * i);
        steps_q[i] <= 5'd0;
      end
    end else begin
      // Request is high exactly for the first CHECK cycle.
      req_q <= (cur == S_PICK) && pick_valid;
      if ((cur == S_PICK) && !pick_valid) tcnt <= tcnt + 16'd1;
      else                                tcnt <= 16'd0;
      case (cur)
        S_IDLE, S_WIN: begin
          if (start) begin
            n_lat    <= N;
            t_q      <= 2'd0;
            winner_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
              pos_q[i]   <= 4'(4 * i);
              steps_q[i] <= 5'd0;
            end
          end
        end
        S_PICK: begin
          if (pick_valid) begin
            card_q   <= pick_tile;
            target_q <= tgt_c;
            dist_q   <= dist_c;
          end
        end
        S_MOVE: begin
          pos_q[t_q]   <= target_q;
          steps_q[t_q] <= steps_new;
          if (win_hit) winner_q <= t_q;
        end
        S_NEXT: t_q <= (t_q == n_lat) ? 2'd0 : t_q + 2'd1;
        default: ;
      endcase
    end
  end

  assign same_req      = req_q;
  assign card_sel      = card_q;
  assign position_data = target_q;
  assign T             = t_q;
  assign winner        = winner_q;
  assign state         = cur;
  assign positions     = {pos_q[3], pos_q[2], pos_q[1], pos_q[0]};

endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - self-checking bench for turn_controller
module tb_turn_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, pick_valid, same_done, same_result;
  logic [1:0] n_in;
  logic [3:0] pick_tile;
  int         sel;

  // Instance a: default parameters. Instance b: WIN_STEPS=3, TIMEOUT_CYCLES=5.
  logic a_start, a_pv, a_sd, b_start, b_pv, b_sd;
  assign a_start = start && (sel == 0);
  assign a_pv    = pick_valid && (sel == 0);
  assign a_sd    = same_done && (sel == 0);
  assign b_start = start && (sel == 1);
  assign b_pv    = pick_valid && (sel == 1);
  assign b_sd    = same_done && (sel == 1);

  logic        a_pr, a_sr, a_nt, a_ms, a_win, b_pr, b_sr, b_nt, b_ms, b_win;
  logic [3:0]  a_cs, a_pd, b_cs, b_pd;
  logic [1:0]  a_T, a_wn, b_T, b_wn;
  logic [15:0] a_pos, b_pos;
  logic [2:0]  a_st, b_st;

  turn_controller dut_a (
    .clk(clk), .rst(rst), .start(a_start), .N(n_in),
    .pick_valid(a_pv), .pick_tile(pick_tile), .pick_ready(a_pr),
    .same_req(a_sr), .card_sel(a_cs), .position_data(a_pd),
    .same_done(a_sd), .same_result(same_result), .T(a_T),
    .statecombo_next_turn(a_nt), .move_strobe(a_ms), .positions(a_pos),
    .win(a_win), .winner(a_wn), .state(a_st)
  );

  turn_controller #(.WIN_STEPS(3), .TIMEOUT_CYCLES(5)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .N(n_in),
    .pick_valid(b_pv), .pick_tile(pick_tile), .pick_ready(b_pr),
    .same_req(b_sr), .card_sel(b_cs), .position_data(b_pd),
    .same_done(b_sd), .same_result(same_result), .T(b_T),
    .statecombo_next_turn(b_nt), .move_strobe(b_ms), .positions(b_pos),
    .win(b_win), .winner(b_wn), .state(b_st)
  );

  logic        o_pr, o_sr, o_nt, o_ms, o_win;
  logic [3:0]  o_cs, o_pd;
  logic [1:0]  o_T, o_wn;
  logic [15:0] o_pos;
  logic [2:0]  o_st;
  assign o_pr  = sel ? b_pr  : a_pr;
  assign o_sr  = sel ? b_sr  : a_sr;
  assign o_nt  = sel ? b_nt  : a_nt;
  assign o_ms  = sel ? b_ms  : a_ms;
  assign o_win = sel ? b_win : a_win;
  assign o_cs  = sel ? b_cs  : a_cs;
  assign o_pd  = sel ? b_pd  : a_pd;
  assign o_T   = sel ? b_T   : a_T;
  assign o_wn  = sel ? b_wn  : a_wn;
  assign o_pos = sel ? b_pos : a_pos;
  assign o_st  = sel ? b_st  : a_st;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: game rules on plain integers.
  int mpos[4];
  int msteps[4];
  int mt, mn, mwinner, mwin_steps;
  bit mwin;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      mpos[i] = 4 * i;
      msteps[i] = 0;
    end
    mt = 0;
    mwin = 0;
    mwinner = 0;
  endtask

  function automatic logic [31:0] m_positions();
    return 32'(mpos[0] + 16 * mpos[1] + 256 * mpos[2] + 4096 * mpos[3]);
  endfunction

  task automatic m_target(output int tgt, output int d);
    tgt = -1;
    d = 0;
    for (int k = 1; k <= 4; k++) begin
      int c;
      bit used;
      c = (mpos[mt] + k) % 16;
      used = 0;
      for (int j = 0; j <= mn; j++)
        if (j != mt && mpos[j] == c) used = 1;
      if (tgt < 0 && !used) begin
        tgt = c;
        d = k;
      end
    end
  endtask

  task automatic check_reset_values();
    chk("rst_state", 32'(o_st), 0);
    chk("rst_positions", 32'(o_pos), 32'hC840);
    chk("rst_T", 32'(o_T), 0);
    chk("rst_strobes", 32'({o_sr, o_nt, o_ms, o_pr}), 0);
    chk("rst_win", 32'({o_win, o_wn}), 0);
    chk("rst_card_pd", 32'({o_cs, o_pd}), 0);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    check_reset_values();
  endtask

  task automatic do_start(input int nv);
    chk("start_from_idle_or_win", 32'(o_st == 3'd0 || o_st == 3'd5), 1);
    start = 1'b1;
    n_in = 2'(nv);
    @(negedge clk);
    start = 1'b0;
    mn = nv;
    m_reset();
    chk("start_state", 32'(o_st), 1);
    chk("start_pick_ready", 32'(o_pr), 1);
    chk("start_positions", 32'(o_pos), 32'hC840);
    chk("start_T", 32'(o_T), 0);
    chk("start_win", 32'(o_win), 0);
  endtask

  task automatic do_turn(input logic [3:0] tile, input bit res, input int delay);
    int tgt, d;
    logic [31:0] oldpos;
    chk("pick_state", 32'(o_st), 1);
    chk("pick_ready", 32'(o_pr), 1);
    m_target(tgt, d);
    oldpos = m_positions();
    pick_valid = 1'b1;
    pick_tile = tile;
    @(negedge clk);
    pick_valid = 1'b0;
    pick_tile = ~tile;
    chk("check_state", 32'(o_st), 2);
    chk("same_req_first", 32'(o_sr), 1);
    chk("check_pick_ready", 32'(o_pr), 0);
    chk("card_sel", 32'(o_cs), 32'(tile));
    chk("position_data", 32'(o_pd), 32'(tgt));
    for (int i = 0; i < delay; i++) begin
      pick_valid = 1'b1;
      @(negedge clk);
      pick_valid = 1'b0;
      chk("check_wait_state", 32'(o_st), 2);
      chk("same_req_low", 32'(o_sr), 0);
      chk("card_sel_held", 32'(o_cs), 32'(tile));
    end
    same_done = 1'b1;
    same_result = res;
    @(negedge clk);
    same_done = 1'b0;
    same_result = 1'b0;
    if (res) begin
      chk("move_state", 32'(o_st), 3);
      chk("move_strobe", 32'(o_ms), 1);
      chk("nt_in_move", 32'(o_nt), 0);
      chk("position_data_move", 32'(o_pd), 32'(tgt));
    end else begin
      chk("next_state", 32'(o_st), 4);
      chk("next_pulse", 32'(o_nt), 1);
      chk("ms_in_next", 32'(o_ms), 0);
    end
    chk("pos_before_update", 32'(o_pos), oldpos);
    chk("T_before_update", 32'(o_T), 32'(mt));
    if (res) begin
      mpos[mt] = tgt;
      msteps[mt] = (msteps[mt] + d > 31) ? 31 : msteps[mt] + d;
      if (msteps[mt] >= mwin_steps) begin
        mwin = 1;
        mwinner = mt;
      end
    end else begin
      mt = (mt == mn) ? 0 : mt + 1;
    end
    @(negedge clk);
    chk("positions", 32'(o_pos), m_positions());
    chk("T", 32'(o_T), 32'(mt));
    chk("win", 32'(o_win), 32'(mwin));
    chk("state_after_turn", 32'(o_st), mwin ? 5 : 1);
    if (mwin) chk("winner", 32'(o_wn), 32'(mwinner));
    chk("strobes_clear", 32'({o_ms, o_nt, o_sr}), 0);
  endtask

  task automatic do_timeout();
    for (int i = 0; i < 5; i++) begin
      chk("timeout_wait_pick", 32'(o_st), 1);
      @(negedge clk);
    end
    chk("timeout_next_state", 32'(o_st), 4);
    chk("timeout_next_pulse", 32'(o_nt), 1);
    mt = (mt == mn) ? 0 : mt + 1;
    @(negedge clk);
    chk("timeout_back_to_pick", 32'(o_st), 1);
    chk("timeout_T", 32'(o_T), 32'(mt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pick_valid = 1'b0;
    same_done = 1'b0;
    same_result = 1'b0;
    n_in = 2'd0;
    pick_tile = 4'd0;
    sel = 0;
    mn = 0;
    mwin_steps = 16;
    m_reset();
    repeat (2) @(negedge clk);
    check_reset_values();
    sel = 1;
    #1;
    check_reset_values();
    sel = 0;
    rst = 1'b0;
    @(negedge clk);

    // Mismatch rotation with three players.
    do_start(2);
    for (int i = 0; i < 3; i++) do_turn(4'($urandom_range(0, 15)), 1'b0, $urandom_range(0, 2));
    chk("rotation_T_wrapped", 32'(o_T), 0);

    // Match and skip: player 1 walks round to cell 1, then player 0 jumps it.
    rst_pulse();
    do_start(1);
    do_turn(4'd3, 1'b0, 0);
    for (int i = 0; i < 12; i++) do_turn(4'($urandom_range(0, 15)), 1'b1, $urandom_range(0, 2));
    chk("skip_setup_p1", 32'(o_pos[7:4]), 1);
    do_turn(4'd5, 1'b0, 1);
    do_turn(4'd9, 1'b1, 0);
    chk("skip_p0_cell", 32'(o_pos[3:0]), 2);
    chk("skip_pd", 32'(o_pd), 2);
    chk("skip_T_kept", 32'(o_T), 0);

    // Reset while waiting in CHECK; a late result must be dropped.
    rst_pulse();
    do_start(3);
    pick_valid = 1'b1;
    pick_tile = 4'd7;
    @(negedge clk);
    pick_valid = 1'b0;
    chk("rc_in_check", 32'(o_st), 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rc_state_now", 32'(o_st), 0);
    chk("rc_positions", 32'(o_pos), 32'hC840);
    chk("rc_no_move", 32'({o_ms, o_sr}), 0);
    @(negedge clk);
    rst = 1'b0;
    same_done = 1'b1;
    same_result = 1'b1;
    @(negedge clk);
    same_done = 1'b0;
    same_result = 1'b0;
    chk("rc_late_done_state", 32'(o_st), 0);
    chk("rc_late_done_ms", 32'(o_ms), 0);
    @(negedge clk);
    chk("rc_still_idle", 32'(o_st), 0);
    chk("rc_positions_kept", 32'(o_pos), 32'hC840);
    m_reset();

    // Randomized games on the default instance.
    do_start($urandom_range(0, 3));
    for (int i = 0; i < 60; i++) begin
      do_turn(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), $urandom_range(0, 3));
      if (mwin) begin
        @(negedge clk);
        chk("win_holds", 32'(o_st), 5);
        do_start($urandom_range(0, 3));
      end
    end

    // Instance b: win with WIN_STEPS=3, then restart.
    sel = 1;
    mwin_steps = 3;
    rst_pulse();
    do_start(0);
    for (int i = 0; i < 3; i++) do_turn(4'($urandom_range(0, 15)), 1'b1, $urandom_range(0, 2));
    chk("win_flag", 32'(o_win), 1);
    chk("win_winner", 32'(o_wn), 0);
    do_start(0);

    // Timeout on instance b with two players.
    rst_pulse();
    do_start(1);
    do_timeout();
    do_turn(4'd2, 1'b1, 1);
    do_timeout();
    for (int i = 0; i < 6 && !mwin; i++)
      do_turn(4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turn_controller.md
# turn_controller

Game sequencer for the chicken-race datapath. It runs the turn loop: accept a tile pick from the current player, issue a match-check request, and on the result either move that player's chicken or hand the turn to the next player. It also owns player positions, per-player step counts and win detection, and drives the turn index `T` and the `statecombo_next_turn` strobe consumed by the datapath's turn logic.

## Interface
Parameters:
- `WIN_STEPS`, default 16: cells a chicken must advance to win. Legal range 1..31.
- `TIMEOUT_CYCLES`, default 0: maximum cycles to wait in PICK before the turn is forfeited. 0 disables the timeout. Counter width is 16 bits.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a game; honoured only in IDLE or WIN.
- `N` in 2: player count minus 1 (1..4 players); latched when `start` is accepted.
- `pick_valid` in 1: player has flipped a tile.
- `pick_tile` in 4: index of the flipped tile.
- `pick_ready` out 1: high only in PICK.
- `same_req` out 1: single-cycle check request to the match checker.
- `card_sel` out 4: latched `pick_tile`; held stable from accept until CHECK exits.
- `position_data` out 4: target cell of the current chicken; valid whenever `same_req` is high and through MOVE.
- `same_done` in 1: checker result valid; honoured only in CHECK.
- `same_result` in 1: 1 means the tile matches the target cell; sampled when `same_done` is high.
- `T` out 2: current player.
- `statecombo_next_turn` out 1: one-cycle pulse when the turn passes.
- `move_strobe` out 1: one-cycle pulse when a chicken moves.
- `positions` out 16: cell of player i at bits [4i+3:4i].
- `win` out 1: high in WIN.
- `winner` out 2: winning player; valid while `win` is high.
- `state` out 3: IDLE=0, PICK=1, CHECK=2, MOVE=3, NEXT=4, WIN=5.

## Operation
- **Reset:**
  - State IDLE, `T`=0.
  - `positions` = {12,8,4,0}, i.e. player i at cell 4i. All step counters 0.
  - All strobes 0, `win`=0, `winner`=0, `card_sel`=0, `position_data`=0.
- **IDLE/WIN + `start`:**
  - Latch `N`, then reload positions, steps and `T` to their reset values and clear `win`.
  - Go to PICK.
- **PICK:**
  - `pick_ready`=1.
  - On `pick_valid`: latch `card_sel`, compute the target and go to CHECK.
  - The target is the first cell after `positions[T]`, mod 16, not occupied by another active player (player index ≤ latched N).
  - The skip distance is d, with 1 ≤ d ≤ 4.
- **Timeout:** if `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES` without a pick, go to NEXT. The counter clears on every entry to PICK.
- **CHECK:**
  - Assert `same_req` on the first cycle only, then wait for `same_done`.
  - `same_result`=1 goes to MOVE; 0 goes to NEXT.
  - `pick_valid` is ignored here.
- **MOVE (1 cycle):**
  - `positions[T]` ← target; `steps[T]` ← `steps[T]`+d, saturating at 31; `move_strobe`=1.
  - If the new steps ≥ `WIN_STEPS`, go to WIN with `winner`=T.
  - Otherwise return to PICK; the same player keeps the turn.
- **NEXT (1 cycle):**
  - `statecombo_next_turn`=1.
  - `T` ← (T==latched N) ? 0 : T+1. With one player, `T` stays 0.
  - Go to PICK.
- **WIN:** holds until `start` or `rst`.
- **Inactive players:** positions and steps of inactive players are frozen and excluded from occupancy checks.

## Timing
- `start` accept to `pick_ready`=1: 1 cycle.
- Pick accepted at edge k: CHECK from k+1, with `same_req`=1 during cycle k+1 only.
- `same_done` at edge m: MOVE or NEXT occupies cycle m+1, and PICK resumes at m+2.
- `same_done` arriving in the same cycle as `same_req` is legal.
- `T`, `positions` and `steps` update on the edge that leaves MOVE or NEXT.
- `same_done` or `pick_valid` asserted in any other state: no effect.
- `rst` mid-turn: immediate return to the reset values listed above; any outstanding checker result is dropped.

## Test plan
- **Reset defaults:** `rst` pulse → `state`=0, `positions`=16'hC840, `T`=0, every strobe 0.
- **Mismatch rotation:** N=2; three consecutive `same_result`=0 picks → `T` runs 0→1→2→0, with exactly one `statecombo_next_turn` pulse each, one cycle after `same_done`.
- **Match and skip:**
  - Setup: N=1, player 1 forced to cell 1 via prior moves; player 0 at cell 0.
  - Stimulus: player 0 match.
  - Required: `position_data`=2, `positions[3:0]`=2, steps +2, `T` unchanged.
- **Win:** `WIN_STEPS`=3, N=0; three matches → `win`=1 and `winner`=0 after the third MOVE. A further `start` resets positions and `win`=0.
- **Timeout:** `TIMEOUT_CYCLES`=5, no pick → NEXT entered 5 cycles after PICK entry, `T` advances.
- **Reset during CHECK:** `rst` asserted while waiting for `same_done` → IDLE at once, no `move_strobe`; a late `same_done` is ignored.
